ldtu_oser_readout: RTL and testbench

LDTU_OSER_READOUT -- requirements
Module: ldtu_oser_readout

---
 rtl/ldtu_oser_readout_if.sv | 27 ++
 rtl/ldtu_oser_readout.sv | 111 +++++++++++
 tb/tb_ldtu_oser_readout.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ldtu_oser_readout_if.sv
// Output-FIFO / serial-lane bundle of the LDTU readout serializer.
// master = serializer side, slave = FIFO + link side.
interface ldtu_oser_readout_if #(
  parameter int unsigned Nbits_32  = 32,
  parameter int unsigned Nbits_out = 8
);
  localparam int unsigned WcW = 16;

  logic                 sync_mode;
  logic [Nbits_32-1:0]  DATA32_DTU;
  logic                 read_signal;
  logic [Nbits_out-1:0] data_out;
  logic                 word_start;
  logic                 idle_flag;
  logic                 sync_active;
  logic [WcW-1:0]       word_count;

  modport master (
    input  sync_mode, DATA32_DTU,
    output read_signal, data_out, word_start, idle_flag, sync_active, word_count
  );

  modport slave (
    output sync_mode, DATA32_DTU,
    input  read_signal, data_out, word_start, idle_flag, sync_active, word_count
  );
endinterface

// File: rtl/ldtu_oser_readout.sv
// LDTU output serializer: pulls 32-bit words from the output FIFO and emits
// them MSB byte first on an 8-bit lane, inserting alignment words while in SYNC.
module ldtu_oser_readout #(
  parameter int unsigned         Nbits_32       = 32,
  parameter int unsigned         Nbits_out      = 8,
  parameter int unsigned         SyncWords      = 16,
  parameter logic [Nbits_32-1:0] idle_patternEA = 32'hEAAAAAAA,
  parameter logic [Nbits_32-1:0] idle_pattern5A = 32'h5A5A5A5A
) (
  input  logic                 CLK,
  input  logic                 reset,
  ldtu_oser_readout_if.master  bus
);

  localparam int unsigned CntW     = 2;
  localparam int unsigned SyncCntW = 5;
  localparam int unsigned WcW      = 16;

  localparam logic [CntW-1:0]     CntLast    = CntW'(3);
  localparam logic [CntW-1:0]     CntDecide  = CntW'(1);
  localparam logic [CntW-1:0]     CntRead    = CntW'(2);
  localparam logic [SyncCntW-1:0] SyncCntMax = '1;
  localparam logic [SyncCntW-1:0] SyncThr    = SyncCntW'(SyncWords);
  localparam logic [WcW-1:0]      WcMax      = '1;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [SyncCntW-1:0]   sync_cnt_q, sync_cnt_d;
  logic [Nbits_32-1:0]   sreg_q, sreg_d;
  logic                  read_q, read_d;
  logic                  idle_q, idle_d;
  logic                  word_start_q, word_start_d;
  logic [WcW-1:0]        word_count_q, word_count_d;

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state_q <= SYNC;
    else       state_q <= state_d;
  end

  // Next state: mode decisions only at the edge ending byte 1 of a word
  always_comb begin
    state_d = state_q;
    if (cnt_q == CntDecide) begin
      unique case (state_q)
        SYNC: if (!bus.sync_mode && (sync_cnt_q >= SyncThr)) state_d = RUN;
        RUN:  if (bus.sync_mode)                             state_d = SYNC;
      endcase
    end
  end

  // Datapath next values; word loads happen at the edge ending byte 3
  always_comb begin
    cnt_d        = cnt_q + CntW'(1);
    sync_cnt_d   = sync_cnt_q;
    sreg_d       = sreg_q << Nbits_out;
    idle_d       = idle_q;
    word_count_d = word_count_q;
    word_start_d = (cnt_d == '0);
    read_d       = (cnt_d == CntRead) && (state_d == RUN);

    if ((state_q == RUN) && (state_d == SYNC)) sync_cnt_d = '0;

    if (cnt_q == CntLast) begin
      if (state_q == SYNC) begin
        sreg_d = idle_pattern5A;
        idle_d = 1'b0;
        if (sync_cnt_q != SyncCntMax) sync_cnt_d = sync_cnt_q + SyncCntW'(1);
      end else begin
        sreg_d = bus.DATA32_DTU;
        idle_d = (bus.DATA32_DTU == idle_patternEA);
        if ((bus.DATA32_DTU != idle_patternEA) && (word_count_q != WcMax))
          word_count_d = word_count_q + WcW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      sync_cnt_q   <= '0;
      sreg_q       <= idle_pattern5A;
      read_q       <= 1'b0;
      idle_q       <= 1'b0;
      word_start_q <= 1'b1;
      word_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      sreg_q       <= sreg_d;
      read_q       <= read_d;
      idle_q       <= idle_d;
      word_start_q <= word_start_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.data_out    = sreg_q[Nbits_32-1 -: Nbits_out];
  assign bus.word_start  = word_start_q;
  assign bus.read_signal = read_q;
  assign bus.idle_flag   = idle_q;
  assign bus.sync_active = (state_q == SYNC);
  assign bus.word_count  = word_count_q;

endmodule

// File: tb/tb_ldtu_oser_readout.sv
// Bench for ldtu_oser_readout: word-level reference model, per-cycle compare,
// directed startup / sync / saturation / reset scenarios plus random sync_mode.
module tb_ldtu_oser_readout;

  localparam int unsigned FifoDepth = 4096;
  localparam logic [31:0] PatEA = 32'hEAAAAAAA;
  localparam logic [31:0] Pat5A = 32'h5A5A5A5A;

  logic CLK   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ldtu_oser_readout_if bus ();

  ldtu_oser_readout dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // FIFO stand-in: next word appears at the edge ending a request cycle
  logic [31:0] fifo_mem [FifoDepth];
  int          env_ptr = 0;
  always @(posedge CLK) begin
    if (bus.read_signal) begin
      bus.DATA32_DTU <= fifo_mem[env_ptr % FifoDepth];
      env_ptr        <= env_ptr + 1;
    end
  end

  // Reference model: one word per 4-cycle slot, mode chosen once per slot
  int          m_cyc = 0;
  bit          m_run = 1'b0;
  int          m_ep = 0;
  logic [31:0] m_word = Pat5A;
  logic [31:0] m_fetched = '0;
  bit          m_is_data = 1'b0;
  logic [15:0] m_wc = '0;
  int          m_fptr = 0;
  int          m_seen_gen = 0;
  int          preload_gen = 0;
  logic [15:0] preload_val = '0;

  initial forever begin
    @(posedge CLK or posedge reset);
    if (reset) begin
      m_cyc = 0; m_run = 1'b0; m_ep = 0; m_word = Pat5A; m_is_data = 1'b0; m_wc = '0;
    end else begin
      if (preload_gen != m_seen_gen) begin
        m_seen_gen = preload_gen;
        m_wc = preload_val;
      end
      case (m_cyc % 4)
        1: begin
          if (m_run && bus.sync_mode) begin m_run = 1'b0; m_ep = 0; end
          else if (!m_run && !bus.sync_mode && m_ep >= 16) m_run = 1'b1;
        end
        2: if (m_run) begin
          m_fetched = fifo_mem[m_fptr % FifoDepth];
          m_fptr++;
        end
        3: begin
          if (m_run) begin
            m_word = m_fetched; m_is_data = 1'b1;
            if (m_fetched != PatEA && m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
          end else begin
            m_word = Pat5A; m_is_data = 1'b0; m_ep++;
          end
        end
        default: ;
      endcase
      m_cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: advance to mid-cycle and compare every output against the model
  task automatic tick();
    logic [7:0] eb;
    @(negedge CLK);
    eb = 8'(m_word >> (8 * (3 - (m_cyc % 4))));
    chk("data_out",    32'(bus.data_out),    32'(eb));
    chk("word_start",  32'(bus.word_start),  32'((m_cyc % 4) == 0));
    chk("read_signal", 32'(bus.read_signal), 32'(m_run && (m_cyc % 4) == 2));
    chk("idle_flag",   32'(bus.idle_flag),   32'(m_is_data && m_word == PatEA));
    chk("sync_active", 32'(bus.sync_active), 32'(!m_run));
    chk("word_count",  32'(bus.word_count),  32'(m_wc));
  endtask

  // Startup sequence after reset release with sync_mode low
  task automatic startup(input int ncyc, input bit first);
    logic [7:0] first_bytes [4];
    logic [7:0] ea_bytes [4];
    first_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
    ea_bytes    = '{8'hEA, 8'hAA, 8'hAA, 8'hAA};
    for (int c = 0; c < ncyc; c++) begin
      tick();
      chk("model_cycle", 32'(m_cyc), 32'(c));
      if (c <= 67) chk("align_byte", 32'(bus.data_out), 32'h5A);
      if (c == 65) begin
        chk("sync_before_66", 32'(bus.sync_active), 32'd1);
        chk("no_read_65",     32'(bus.read_signal), 32'd0);
      end
      if (c == 66) begin
        chk("sync_fall_66",  32'(bus.sync_active), 32'd0);
        chk("first_read_66", 32'(bus.read_signal), 32'd1);
      end
      if (first && c >= 68 && c <= 71) begin
        chk("word1_byte", 32'(bus.data_out), 32'(first_bytes[c - 68]));
        chk("word1_wc",   32'(bus.word_count), 32'd1);
        chk("word1_start", 32'(bus.word_start), 32'(c == 68));
      end
      if (first && c >= 72 && c <= 75) begin
        chk("idle_byte", 32'(bus.data_out), 32'(ea_bytes[c - 72]));
        chk("idle_flag_hi", 32'(bus.idle_flag), 32'd1);
        chk("idle_wc", 32'(bus.word_count), 32'd1);
      end
    end
  endtask

  task automatic wait_run(input int limit);
    int n = 0;
    while (bus.sync_active && n < limit) begin tick(); n++; end
    chk("reach_run", 32'(bus.sync_active), 32'd0);
  endtask

  initial begin
    int  n_rd;
    int  n;
    bit  found;

    for (int i = 0; i < FifoDepth; i++)
      fifo_mem[i] = ($urandom_range(0, 3) == 0) ? PatEA : $urandom();
    fifo_mem[0] = 32'h12345678;
    fifo_mem[1] = PatEA;
    bus.sync_mode = 1'b0;

    repeat (3) tick();
    chk("rst_data_out",    32'(bus.data_out),    32'h5A);
    chk("rst_word_start",  32'(bus.word_start),  32'd1);
    chk("rst_sync_active", 32'(bus.sync_active), 32'd1);
    chk("rst_read_signal", 32'(bus.read_signal), 32'd0);
    chk("rst_word_count",  32'(bus.word_count),  32'd0);

    @(posedge CLK); #1 reset = 1'b0;
    startup(76, 1'b1);

    // sync_mode high only around a cnt==2 cycle must be ignored
    n = 0;
    while ((m_cyc % 4) != 2 && n < 8) begin tick(); n++; end
    bus.sync_mode = 1'b1;
    tick();
    bus.sync_mode = 1'b0;
    repeat (20) tick();
    chk("pulse_ignored", 32'(bus.sync_active), 32'd0);

    // sync_mode held across a decision edge: reads stop, long alignment run
    bus.sync_mode = 1'b1;
    repeat (12) tick();
    chk("held_sync", 32'(bus.sync_active), 32'd1);
    bus.sync_mode = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.read_signal) n_rd++;
    end
    chk("no_reads_in_sync", 32'(n_rd), 32'd0);
    chk("still_sync", 32'(bus.sync_active), 32'd1);

    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 79) == 0) bus.sync_mode = ~bus.sync_mode;
      tick();
    end

    // word_count saturation from a preloaded value
    bus.sync_mode = 1'b0;
    wait_run(300);
    preload_val = 16'hFFFC;
    force dut.word_count_q = 16'hFFFC;
    #1 release dut.word_count_q;
    preload_gen++;
    repeat (120) tick();
    chk("wc_saturated", 32'(bus.word_count), 32'h0000FFFF);

    // reset in the middle of a data word
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (m_run && (m_cyc % 4) == 1 && m_is_data) found = 1'b1;
    end
    chk("found_midword", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_data_out",    32'(bus.data_out),    32'h5A);
    chk("arst_read_signal", 32'(bus.read_signal), 32'd0);
    chk("arst_word_start",  32'(bus.word_start),  32'd1);
    chk("arst_sync_active", 32'(bus.sync_active), 32'd1);
    chk("arst_word_count",  32'(bus.word_count),  32'd0);
    repeat (3) tick();
    @(posedge CLK); #1 reset = 1'b0;
    startup(68, 1'b0);
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
